fir_complex_decim: RTL and testbench
====================================

FIR_COMPLEX_DECIM -- requirements
Module: fir_complex_decim

Interface
REQ-001 SHALL have parameter TAP_COUNT, default 20, number of complex taps (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, signed sample width per I/Q component.
REQ-003 SHALL have parameter COEF_WIDTH, default 32, signed coefficient width per real/imag component.
REQ-004 SHALL have parameter MULT_PER_CYCLE, default 1, complex products per MAC cycle; must divide TAP_COUNT (elaboration error otherwise).
REQ-005 SHALL have parameter DECIMATION_FACTOR, default 1, input samples consumed per output sample (>=1).
REQ-006 SHALL have parameter DEQUANT_SHIFT, default 10, final scaling = divide by 2^DEQUANT_SHIFT.
REQ-007 SHALL have ports: clock in 1 rising-edge clock; reset in 1 asynchronous active-high reset.
REQ-008 SHALL have ports: in_empty in 1 input FIFO empty; in_rd_en out 1 input pop; Iin, Qin in DATA_WIDTH each, input sample.
REQ-009 SHALL have ports: out_full in 1 output FIFO full; out_wr_en out 1 output push; Iout, Qout out DATA_WIDTH each, filtered sample.
REQ-010 SHALL have ports: coef_wr_en in 1; coef_addr in $clog2(TAP_COUNT); coef_re, coef_im in COEF_WIDTH each; busy out 1 (high whenever state != SHIFT).

Function
REQ-011 SHALL implement states SHIFT, MAC, DEQUANT, OUTPUT.
REQ-012 In SHIFT, in_rd_en SHALL equal !in_empty; a sample is accepted only when in_rd_en is high, shifting I/Q delay lines by one (newest at index 0, oldest discarded).
REQ-013 A decimation counter SHALL count accepted samples; on the DECIMATION_FACTOR-th accept, counter clears, accumulators clear, state -> MAC next cycle.
REQ-014 MAC SHALL last exactly TAP_COUNT/MULT_PER_CYCLE cycles, each adding MULT_PER_CYCLE products, tap index k = cycle*MULT_PER_CYCLE + lane.
REQ-015 Per tap: accRe += hr[k]*xi[k] - hi[k]*xq[k]; accIm += hr[k]*xq[k] + hi[k]*xi[k]; all operands signed.
REQ-016 Accumulators SHALL be DATA_WIDTH+COEF_WIDTH+$clog2(TAP_COUNT)+1 bits; no overflow possible.
REQ-017 DEQUANT (1 cycle) SHALL divide each accumulator by 2^DEQUANT_SHIFT, truncating toward zero, then keep the low DATA_WIDTH bits into Iout(Re)/Qout(Im) registers.
REQ-018 OUTPUT: out_wr_en = !out_full; on push state -> SHIFT; while out_full high, hold state, Iout/Qout stable.
REQ-019 Latency: accept at cycle t triggering compute -> out_wr_en earliest at t+M+2, M = TAP_COUNT/MULT_PER_CYCLE.
REQ-020 in_rd_en SHALL be 0 outside SHIFT; out_wr_en SHALL be 0 outside OUTPUT.
REQ-021 Coefficient write (coef_wr_en high) SHALL take effect next cycle only in SHIFT; ignored in other states; coef_addr >= TAP_COUNT ignored.
REQ-022 Coefficient write and sample accept in same cycle both SHALL occur; a compute started that cycle uses the new coefficient.

Reset
REQ-023 Reset SHALL force: state SHIFT, delay lines 0, accumulators 0, decimation counter 0, Iout/Qout 0, in_rd_en/out_wr_en 0 while asserted, busy 0.
REQ-024 Reset SHALL load coefficients hr[0]=2^DEQUANT_SHIFT, all other hr and all hi = 0 (pass-through).
REQ-025 Reset mid-MAC or mid-OUTPUT SHALL abandon the result; no out_wr_en after deassertion until a new compute completes.

Structure
REQ-026 Package fir_complex_pkg SHALL hold the state enum and accumulator-width function.
REQ-027 Sub-module complex_mac SHALL compute one lane's signed complex product pair; top instantiates MULT_PER_CYCLE copies.

Verification
REQ-028 Reset coefficients, DECIM=1, input (I,Q)=(100,-50) -> first output (100,-50) at t+M+2.
REQ-029 Load hr[0]=0,hi[0]=1024, input (3,4) -> output (-4,3).
REQ-030 DECIM=4, 8 inputs streamed -> exactly 2 outputs, only after 4th and 8th accepts.
REQ-031 hr[0]=1, input (-1023,0), DEQUANT_SHIFT=10 -> output 0 (truncation toward zero, not -1).
REQ-032 Hold out_full high 10 cycles in OUTPUT -> in_rd_en 0, Iout/Qout stable, single push after release.
REQ-033 Assert reset during MAC, coef_wr_en during MAC -> no output, coefficients at reset defaults.

Source files
------------

// File: rtl/fir_complex_pkg.sv
// Shared types for the decimating complex FIR.
// Holds the FSM encoding and accumulator sizing.
package fir_complex_pkg;

  typedef enum logic [1:0] {
    SHIFT,
    MAC,
    DEQUANT,
    OUTPUT
  } state_t;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/complex_mac.sv
// One lane of the complex multiplier.
// Produces the signed real/imag product pair for one tap.
module complex_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]         xi,
  input  logic [DATA_WIDTH-1:0]         xq,
  input  logic [COEF_WIDTH-1:0]         hr,
  input  logic [COEF_WIDTH-1:0]         hi,
  output logic [DATA_WIDTH+COEF_WIDTH:0] pr,
  output logic [DATA_WIDTH+COEF_WIDTH:0] pi
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;

  logic signed [PW-1:0] xi_s;
  logic signed [PW-1:0] xq_s;
  logic signed [PW-1:0] hr_s;
  logic signed [PW-1:0] hi_s;

  assign xi_s = {{(PW-DATA_WIDTH){xi[DATA_WIDTH-1]}}, xi};
  assign xq_s = {{(PW-DATA_WIDTH){xq[DATA_WIDTH-1]}}, xq};
  assign hr_s = {{(PW-COEF_WIDTH){hr[COEF_WIDTH-1]}}, hr};
  assign hi_s = {{(PW-COEF_WIDTH){hi[COEF_WIDTH-1]}}, hi};

  assign pr = hr_s * xi_s - hi_s * xq_s;
  assign pi = hr_s * xq_s + hi_s * xi_s;

endmodule

// File: rtl/fir_complex_decim.sv
// Decimating complex FIR with FIFO-style ports.
// Time-multiplexed MAC over MULT_PER_CYCLE lanes.
module fir_complex_decim
  import fir_complex_pkg::*;
#(
  parameter int TAP_COUNT         = 20,
  parameter int DATA_WIDTH        = 32,
  parameter int COEF_WIDTH        = 32,
  parameter int MULT_PER_CYCLE    = 1,
  parameter int DECIMATION_FACTOR = 1,
  parameter int DEQUANT_SHIFT     = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  input  logic [DATA_WIDTH-1:0]        Iin,
  input  logic [DATA_WIDTH-1:0]        Qin,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic [DATA_WIDTH-1:0]        Iout,
  output logic [DATA_WIDTH-1:0]        Qout,
  input  logic                         coef_wr_en,
  input  logic [$clog2(TAP_COUNT)-1:0] coef_addr,
  input  logic [COEF_WIDTH-1:0]        coef_re,
  input  logic [COEF_WIDTH-1:0]        coef_im,
  output logic                         busy
);

  localparam int M      = TAP_COUNT / MULT_PER_CYCLE;
  localparam int AW     = $clog2(TAP_COUNT);
  localparam int MC_W   = (M > 1) ? $clog2(M) : 1;
  localparam int DC_W   =
    (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
  localparam int ACC_W  =
    acc_width(DATA_WIDTH, COEF_WIDTH, TAP_COUNT);
  localparam int PW     = DATA_WIDTH + COEF_WIDTH + 1;
  localparam logic [ACC_W-1:0] BIAS =
    ACC_W'((64'd1 << DEQUANT_SHIFT) - 64'd1);
  localparam logic [COEF_WIDTH-1:0] HR0 =
    COEF_WIDTH'(64'd1 << DEQUANT_SHIFT);

  if (TAP_COUNT % MULT_PER_CYCLE != 0) begin : g_bad_mpc
    $error("MULT_PER_CYCLE must divide TAP_COUNT");
  end

  state_t state, state_nxt;

  logic [MC_W-1:0]       mac_cnt;
  logic [DC_W-1:0]       dec_cnt;
  logic                  accept;
  logic                  last_dec;
  logic                  last_mac;
  logic                  coef_ok;
  logic [DATA_WIDTH-1:0] xi [TAP_COUNT];
  logic [DATA_WIDTH-1:0] xq [TAP_COUNT];
  logic [COEF_WIDTH-1:0] hr [TAP_COUNT];
  logic [COEF_WIDTH-1:0] hi [TAP_COUNT];
  logic [ACC_W-1:0]      acc_re;
  logic [ACC_W-1:0]      acc_im;
  logic [ACC_W-1:0]      sum_re;
  logic [ACC_W-1:0]      sum_im;
  logic [AW-1:0]         k_idx   [MULT_PER_CYCLE];
  logic [PW-1:0]         lane_re [MULT_PER_CYCLE];
  logic [PW-1:0]         lane_im [MULT_PER_CYCLE];

  // Pop is held off during reset even though state reads SHIFT.
  assign in_rd_en  = (state == SHIFT) && !in_empty && !reset;
  assign accept    = in_rd_en;
  assign out_wr_en = (state == OUTPUT) && !out_full;
  assign busy      = state != SHIFT;
  assign last_dec  = dec_cnt == DC_W'(DECIMATION_FACTOR - 1);
  assign last_mac  = mac_cnt == MC_W'(M - 1);
  assign coef_ok   = {1'b0, coef_addr} < (AW+1)'(TAP_COUNT);

  always_comb begin
    state_nxt = state;
    case (state)
      SHIFT:   if (accept && last_dec) state_nxt = MAC;
      MAC:     if (last_mac) state_nxt = DEQUANT;
      DEQUANT: state_nxt = OUTPUT;
      OUTPUT:  if (!out_full) state_nxt = SHIFT;
      default: state_nxt = SHIFT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SHIFT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAP_COUNT; k++) begin
        xi[k] <= '0;
        xq[k] <= '0;
        hr[k] <= (k == 0) ? HR0 : '0;
        hi[k] <= '0;
      end
    end else begin
      if (accept) begin
        xi[0] <= Iin;
        xq[0] <= Qin;
        for (int k = 1; k < TAP_COUNT; k++) begin
          xi[k] <= xi[k-1];
          xq[k] <= xq[k-1];
        end
      end
      if ((state == SHIFT) && coef_wr_en && coef_ok) begin
        hr[coef_addr] <= coef_re;
        hi[coef_addr] <= coef_im;
      end
    end
  end

  for (genvar l = 0; l < MULT_PER_CYCLE; l++) begin : g_lane
    assign k_idx[l] =
      AW'(int'(mac_cnt) * MULT_PER_CYCLE + l);
    complex_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH)
    ) u_mac (
      .xi (xi[k_idx[l]]),
      .xq (xq[k_idx[l]]),
      .hr (hr[k_idx[l]]),
      .hi (hi[k_idx[l]]),
      .pr (lane_re[l]),
      .pi (lane_im[l])
    );
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int l = 0; l < MULT_PER_CYCLE; l++) begin
      sum_re = sum_re +
        {{(ACC_W-PW){lane_re[l][PW-1]}}, lane_re[l]};
      sum_im = sum_im +
        {{(ACC_W-PW){lane_im[l][PW-1]}}, lane_im[l]};
    end
  end

  // Biasing negatives before the arithmetic shift rounds toward zero.
  function automatic logic [DATA_WIDTH-1:0] dequant(
    input logic [ACC_W-1:0] a
  );
    logic [ACC_W-1:0] b;
    b = a[ACC_W-1] ? a + BIAS : a;
    return DATA_WIDTH'($signed(b) >>> DEQUANT_SHIFT);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mac_cnt <= '0;
      dec_cnt <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      Iout    <= '0;
      Qout    <= '0;
    end else begin
      if (accept) begin
        if (last_dec) begin
          dec_cnt <= '0;
          acc_re  <= '0;
          acc_im  <= '0;
        end else begin
          dec_cnt <= dec_cnt + 1'b1;
        end
      end
      if (state == MAC) begin
        acc_re  <= acc_re + sum_re;
        acc_im  <= acc_im + sum_im;
        mac_cnt <= last_mac ? '0 : mac_cnt + 1'b1;
      end
      if (state == DEQUANT) begin
        Iout <= dequant(acc_re);
        Qout <= dequant(acc_im);
      end
    end
  end

endmodule

// File: tb/tb_fir_complex_decim.sv
// Directed bench for fir_complex_decim.
// Two instances: decimate-by-1 and decimate-by-4.
module tb_fir_complex_decim;

  localparam int TAPS = 4;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int MPC  = 2;
  localparam int SH   = 10;
  localparam int LAT  = TAPS / MPC + 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic                 a_in_empty, a_in_rd_en;
  logic signed [DW-1:0] a_Iin, a_Qin, a_Iout, a_Qout;
  logic                 a_out_full, a_out_wr_en;
  logic                 a_coef_wr_en, a_busy;
  logic [1:0]           a_coef_addr;
  logic [CW-1:0]        a_coef_re, a_coef_im;

  logic                 b_in_empty, b_in_rd_en;
  logic signed [DW-1:0] b_Iin, b_Qin, b_Iout, b_Qout;
  logic                 b_out_full, b_out_wr_en;
  logic                 b_coef_wr_en, b_busy;
  logic [1:0]           b_coef_addr;
  logic [CW-1:0]        b_coef_re, b_coef_im;

  fir_complex_decim #(
    .TAP_COUNT (TAPS), .DATA_WIDTH (DW),
    .COEF_WIDTH (CW), .MULT_PER_CYCLE (MPC),
    .DECIMATION_FACTOR (1), .DEQUANT_SHIFT (SH)
  ) dut_a (
    .clock (clock), .reset (reset),
    .in_empty (a_in_empty), .in_rd_en (a_in_rd_en),
    .Iin (a_Iin), .Qin (a_Qin),
    .out_full (a_out_full), .out_wr_en (a_out_wr_en),
    .Iout (a_Iout), .Qout (a_Qout),
    .coef_wr_en (a_coef_wr_en), .coef_addr (a_coef_addr),
    .coef_re (a_coef_re), .coef_im (a_coef_im),
    .busy (a_busy)
  );

  fir_complex_decim #(
    .TAP_COUNT (TAPS), .DATA_WIDTH (DW),
    .COEF_WIDTH (CW), .MULT_PER_CYCLE (MPC),
    .DECIMATION_FACTOR (4), .DEQUANT_SHIFT (SH)
  ) dut_b (
    .clock (clock), .reset (reset),
    .in_empty (b_in_empty), .in_rd_en (b_in_rd_en),
    .Iin (b_Iin), .Qin (b_Qin),
    .out_full (b_out_full), .out_wr_en (b_out_wr_en),
    .Iout (b_Iout), .Qout (b_Qout),
    .coef_wr_en (b_coef_wr_en), .coef_addr (b_coef_addr),
    .coef_re (b_coef_re), .coef_im (b_coef_im),
    .busy (b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  int a_cnt = 0;
  int a_first_cyc = -1;
  logic signed [DW-1:0] a_last_i, a_last_q;
  int b_cnt = 0;
  int b_acc = 0;
  logic signed [DW-1:0] b_oi[$], b_oq[$];
  int b_acc_at[$];

  always @(negedge clock) begin
    if (a_out_wr_en) begin
      a_cnt++;
      a_last_i = a_Iout;
      a_last_q = a_Qout;
      if (a_first_cyc < 0) a_first_cyc = cyc;
    end
    if (b_out_wr_en) begin
      b_cnt++;
      b_oi.push_back(b_Iout);
      b_oq.push_back(b_Qout);
      b_acc_at.push_back(b_acc);
    end
    if (b_in_rd_en) b_acc++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic push(input bit sel,
                      input logic signed [DW-1:0] i,
                      input logic signed [DW-1:0] q,
                      output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    if (sel) begin
      b_Iin = i; b_Qin = q; b_in_empty = 1'b0;
    end else begin
      a_Iin = i; a_Qin = q; a_in_empty = 1'b0;
    end
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clock);
      if (sel ? b_in_rd_en : a_in_rd_en) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(posedge clock);
    #1;
    a_in_empty = 1'b1;
    b_in_empty = 1'b1;
    check("push_accepted", got, 1);
  endtask

  task automatic wcoef(input int tap, input int re, input int im);
    a_coef_wr_en = 1'b1;
    a_coef_addr  = 2'(tap);
    a_coef_re    = CW'(re);
    a_coef_im    = CW'(im);
    tick(1);
    a_coef_wr_en = 1'b0;
  endtask

  function automatic logic [63:0] quad(input int v0, input int v1,
                                       input int v2, input int v3);
    return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  // Taps indexed 0..3; samples listed oldest push first.
  typedef struct packed {
    logic [63:0] hr;
    logic [63:0] hi;
    logic [63:0] si;
    logic [63:0] sq;
    logic [15:0] ei;
    logic [15:0] eq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t, c0;
    bit bad_rd, bad_hold, bad_wr;

    vecs[0] = '{quad(1024,0,0,0), quad(0,0,0,0),
                quad(1,2,3,100), quad(1,2,3,-50),
                16'sd100, -16'sd50};
    vecs[1] = '{quad(0,0,0,1024), quad(0,0,0,0),
                quad(7,1,1,1), quad(-8,1,1,1),
                16'sd7, -16'sd8};
    vecs[2] = '{quad(0,0,0,0), quad(1024,0,0,0),
                quad(0,0,0,3), quad(0,0,0,4),
                -16'sd4, 16'sd3};
    vecs[3] = '{quad(1024,2048,0,-1024), quad(0,0,0,0),
                quad(10,0,5,1), quad(1,0,2,-3),
                16'sd1, 16'sd0};
    vecs[4] = '{quad(1,0,0,0), quad(0,0,0,0),
                quad(0,0,0,-1023), quad(0,0,0,0),
                16'sd0, 16'sd0};
    vecs[5] = '{quad(512,0,0,0), quad(0,0,0,0),
                quad(0,0,0,-3), quad(0,0,0,3),
                -16'sd1, 16'sd1};
    vecs[6] = '{quad(0,1024,0,0), quad(0,2048,0,0),
                quad(0,0,3,9), quad(0,0,-2,9),
                16'sd7, 16'sd4};

    a_Iin = '0; a_Qin = '0; a_out_full = 1'b0;
    a_coef_wr_en = 1'b0; a_coef_addr = '0;
    a_coef_re = '0; a_coef_im = '0;
    b_Iin = '0; b_Qin = '0; b_out_full = 1'b0;
    b_coef_wr_en = 1'b0; b_coef_addr = '0;
    b_coef_re = '0; b_coef_im = '0;
    b_in_empty = 1'b1;

    // Reset state, with a sample on offer throughout.
    a_in_empty = 1'b0;
    reset = 1'b1;
    tick(2);
    check("rst_in_rd_en", a_in_rd_en, 0);
    check("rst_out_wr_en", a_out_wr_en, 0);
    check("rst_busy", a_busy, 0);
    check("rst_iout", a_Iout, 0);
    check("rst_qout", a_Qout, 0);
    a_in_empty = 1'b1;
    reset = 1'b0;
    tick(1);

    // Pass-through with reset coefficients and latency.
    a_first_cyc = -1;
    c0 = a_cnt;
    push(0, 16'sd100, -16'sd50, t);
    tick(LAT + 4);
    check("lat_cycle", a_first_cyc, t + LAT);
    check("lat_i", a_last_i, 100);
    check("lat_q", a_last_q, -50);
    check("lat_count", a_cnt - c0, 1);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int k = 0; k < TAPS; k++)
        wcoef(k, int'($signed(vecs[v].hr[16*k +: 16])),
                 int'($signed(vecs[v].hi[16*k +: 16])));
      c0 = a_cnt;
      for (int k = 0; k < TAPS; k++)
        push(0, $signed(vecs[v].si[16*k +: 16]),
                $signed(vecs[v].sq[16*k +: 16]), t);
      tick(LAT + 4);
      check($sformatf("vec%0d_i", v), a_last_i,
            $signed(vecs[v].ei));
      check($sformatf("vec%0d_q", v), a_last_q,
            $signed(vecs[v].eq));
      check($sformatf("vec%0d_cnt", v), a_cnt - c0, TAPS);
    end

    // Coefficient write in the same cycle as the triggering accept.
    do_reset();
    a_coef_wr_en = 1'b1;
    a_coef_addr  = 2'd0;
    a_coef_re    = CW'(2048);
    a_coef_im    = '0;
    push(0, 16'sd30, -16'sd7, t);
    a_coef_wr_en = 1'b0;
    tick(LAT + 4);
    check("same_cyc_i", a_last_i, 60);
    check("same_cyc_q", a_last_q, -14);

    // Coefficient write during MAC is dropped.
    do_reset();
    push(0, 16'sd10, 16'sd20, t);
    wcoef(0, 0, 0);
    tick(LAT + 4);
    push(0, 16'sd10, 16'sd20, t);
    tick(LAT + 4);
    check("mac_wr_ignored_i", a_last_i, 10);
    check("mac_wr_ignored_q", a_last_q, 20);

    // Back-pressure held for ten cycles in OUTPUT.
    do_reset();
    a_out_full = 1'b1;
    c0 = a_cnt;
    push(0, 16'sd55, -16'sd77, t);
    tick(LAT + 2);
    a_Iin = 16'sd1;
    a_Qin = 16'sd1;
    a_in_empty = 1'b0;
    bad_rd = 1'b0; bad_hold = 1'b0; bad_wr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (a_in_rd_en) bad_rd = 1'b1;
      if (a_out_wr_en) bad_wr = 1'b1;
      if (a_Iout !== 16'sd55 || a_Qout !== -16'sd77)
        bad_hold = 1'b1;
    end
    tick(1);
    check("full_busy", a_busy, 1);
    a_in_empty = 1'b1;
    a_out_full = 1'b0;
    check("full_no_rd", bad_rd, 0);
    check("full_no_wr", bad_wr, 0);
    check("full_stable", bad_hold, 0);
    tick(6);
    check("full_one_push", a_cnt - c0, 1);
    check("full_val_i", a_last_i, 55);
    check("full_val_q", a_last_q, -77);

    // Reset in the middle of MAC, with a coefficient write pending.
    do_reset();
    c0 = a_cnt;
    push(0, 16'sd100, -16'sd50, t);
    a_coef_wr_en = 1'b1;
    a_coef_addr  = 2'd0;
    a_coef_re    = '0;
    a_coef_im    = CW'(5);
    tick(1);
    a_coef_wr_en = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("midmac_busy", a_busy, 0);
    check("midmac_iout", a_Iout, 0);
    tick(LAT + 6);
    check("midmac_no_out", a_cnt - c0, 0);
    push(0, 16'sd100, -16'sd50, t);
    tick(LAT + 4);
    check("midmac_coef_i", a_last_i, 100);
    check("midmac_coef_q", a_last_q, -50);
    check("midmac_cnt", a_cnt - c0, 1);

    // Decimate by four: eight samples give two outputs.
    do_reset();
    b_acc = 0;
    c0 = b_cnt;
    b_oi.delete();
    b_oq.delete();
    b_acc_at.delete();
    for (int k = 1; k <= 8; k++)
      push(1, 16'(k), 16'(-k), t);
    tick(LAT + 6);
    check("dec4_count", b_cnt - c0, 2);
    if (b_oi.size() == 2) begin
      check("dec4_first_at", b_acc_at[0], 4);
      check("dec4_second_at", b_acc_at[1], 8);
      check("dec4_first_i", b_oi[0], 4);
      check("dec4_first_q", b_oq[0], -4);
      check("dec4_second_i", b_oi[1], 8);
      check("dec4_second_q", b_oq[1], -8);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
